mult_add_stage: RTL and testbench

//   Registered signed multiply-accumulate cell: p_out <= a_in*b_in + p_in.

---
 rtl/mult_add_stage.sv | 63 ++++++
 tb/tb_mult_add_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/mult_add_stage.sv
// Registered signed multiply-accumulate cell: p_out <= a_in * b_in + p_in.
// One tap of a transposed-form FIR; cells chain p_out -> p_in of the next cell.
module mult_add_stage #(
    parameter int AWIDTH     = 16,
    parameter int BWIDTH     = 16,
    parameter int PIN_WIDTH  = 32,
    parameter int POUT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AWIDTH-1:0]     a_in,
    input  logic [BWIDTH-1:0]     b_in,
    input  logic [PIN_WIDTH-1:0]  p_in,
    output logic [POUT_WIDTH-1:0] p_out
);

    localparam int PROD_W = AWIDTH + BWIDTH;

    logic [PROD_W-1:0]     a_ext_s;
    logic [PROD_W-1:0]     b_ext_s;
    logic [PROD_W-1:0]     product_s;
    logic [POUT_WIDTH-1:0] prod_fit_s;
    logic [POUT_WIDTH-1:0] pin_fit_s;
    logic [POUT_WIDTH-1:0] sum_s;
    logic [POUT_WIDTH-1:0] p_out_r;

    // Sign-extend both operands to the full product width; the low PROD_W
    // bits of that product equal the exact signed product.
    assign a_ext_s   = {{BWIDTH{a_in[AWIDTH-1]}}, a_in};
    assign b_ext_s   = {{AWIDTH{b_in[BWIDTH-1]}}, b_in};
    assign product_s = a_ext_s * b_ext_s;

    // The exact wide sum truncated to POUT_WIDTH equals the sum of the operands
    // each first fitted (sign-extended or truncated) to POUT_WIDTH, modulo 2^POUT_WIDTH.
    if (PROD_W >= POUT_WIDTH) begin : g_prod_trunc
        assign prod_fit_s = product_s[POUT_WIDTH-1:0];
    end else begin : g_prod_sext
        assign prod_fit_s = {{(POUT_WIDTH-PROD_W){product_s[PROD_W-1]}}, product_s};
    end

    if (PIN_WIDTH >= POUT_WIDTH) begin : g_pin_trunc
        assign pin_fit_s = p_in[POUT_WIDTH-1:0];
    end else begin : g_pin_sext
        assign pin_fit_s = {{(POUT_WIDTH-PIN_WIDTH){p_in[PIN_WIDTH-1]}}, p_in};
    end

    // Accumulate with two's-complement wrap; no saturation.
    always_comb begin
        sum_s = prod_fit_s + pin_fit_s;
    end

    // Output register: synchronous reset has priority over the new partial sum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_out_r <= {POUT_WIDTH{1'b0}};
        end else begin
            p_out_r <= sum_s;
        end
    end

    assign p_out = p_out_r;

endmodule

// File: tb/tb_mult_add_stage.sv
// Self-checking bench for mult_add_stage: directed and random vectors on one cell,
// plus a 4-cell transposed FIR chain checked against a direct convolution.
module tb_mult_add_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p_in;
    logic [31:0] p_out;
    logic [15:0] a_ch;
    logic [31:0] ch_p0, ch_p1, ch_p2, ch_p3;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_prev;
    bit          prev_valid  = 1'b0;
    longint      hist[$];
    longint      taps[4]     = '{64'sd1, 64'sd2, 64'sd3, 64'sd4};

    always #5 clk = ~clk;

    mult_add_stage #(.AWIDTH(16), .BWIDTH(16), .PIN_WIDTH(32), .POUT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .a_in(a), .b_in(b), .p_in(p_in), .p_out(p_out)
    );

    mult_add_stage cell0 (.clk_i(clk), .rst_i(rst), .a_in(a_ch), .b_in(16'd4), .p_in(32'd0), .p_out(ch_p0));
    mult_add_stage cell1 (.clk_i(clk), .rst_i(rst), .a_in(a_ch), .b_in(16'd3), .p_in(ch_p0), .p_out(ch_p1));
    mult_add_stage cell2 (.clk_i(clk), .rst_i(rst), .a_in(a_ch), .b_in(16'd2), .p_in(ch_p1), .p_out(ch_p2));
    mult_add_stage cell3 (.clk_i(clk), .rst_i(rst), .a_in(a_ch), .b_in(16'd1), .p_in(ch_p2), .p_out(ch_p3));

    // Reference: exact signed arithmetic in 64 bits, then keep the 32 LSBs.
    function automatic logic [31:0] ref_mac(input logic [15:0] ia, input logic [15:0] ib,
                                            input logic [31:0] ip);
        longint r;
        r = longint'($signed(ia)) * longint'($signed(ib)) + longint'($signed(ip));
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [15:0] ia,
                        input logic [15:0] ib, input logic [31:0] ip);
        logic [31:0] e;
        @(negedge clk);
        rst = r; a = ia; b = ib; p_in = ip;
        #1;
        if (prev_valid) check({tag, "_before_edge"}, p_out, exp_prev);
        @(posedge clk);
        #1;
        e = r ? 32'd0 : ref_mac(ia, ib, ip);
        check(tag, p_out, e);
        exp_prev   = e;
        prev_valid = 1'b1;
    endtask

    task automatic chain_step(input string tag, input logic [15:0] x);
        longint y;
        @(negedge clk);
        a_ch = x;
        @(posedge clk);
        #1;
        hist.push_front(longint'($signed(x)));
        y = 64'sd0;
        for (int k = 0; k < 4; k++) begin
            if (k < hist.size()) y += taps[k] * hist[k];
        end
        check(tag, ch_p3, y[31:0]);
    endtask

    initial begin
        rst = 1'b1; a = 16'd0; b = 16'd0; p_in = 32'd0; a_ch = 16'd0;

        step("reset", 1'b1, 16'($urandom), 16'($urandom), 32'($urandom));
        step("reset_hold", 1'b1, 16'($urandom), 16'($urandom), 32'($urandom));

        step("mac_3_4_5", 1'b0, 16'd3, 16'd4, 32'd5);
        step("neg2_x_7", 1'b0, 16'hFFFE, 16'd7, 32'd0);
        step("neg1_all", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF);
        step("min_x_min", 1'b0, 16'h8000, 16'h8000, 32'd0);
        step("min_x_min_wrap", 1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
        step("max_x_min", 1'b0, 16'h7FFF, 16'h8000, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            step("random", 1'b0, 16'($urandom), 16'($urandom), 32'($urandom));
        end

        step("mid_reset", 1'b1, 16'($urandom), 16'($urandom), 32'($urandom));
        step("after_reset", 1'b0, 16'($urandom), 16'($urandom), 32'($urandom));
        step("after_reset2", 1'b0, 16'($urandom), 16'($urandom), 32'($urandom));

        // Chain cells have seen only zero samples so far, so history starts empty.
        chain_step("chain_impulse", 16'd1);
        for (int i = 0; i < 4; i++) chain_step("chain_tail", 16'd0);
        for (int i = 0; i < 20; i++) chain_step("chain_random", 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
